// File: rtl/morse_symbol_classifier.sv
// Classifies synchronised Morse key timing into WAIT/DIT/DAH/GAP/SPACE one-cycle codes.
// Optional input debounce filter is enabled by defining MORSE_DEBOUNCE_EN.
module morse_symbol_classifier #(
    parameter int unsigned DIT_MAX         = 4000,
    parameter int unsigned GAP_MIN         = 6000,
    parameter int unsigned SPACE_MIN       = 14000,
    parameter int unsigned DEBOUNCE_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key,
    output logic [2:0] symbol,
    output logic       markActive
);

    typedef enum logic [1:0] {StIdle, StMark, StLetterGap, StWordGap} state_e;

    localparam logic [2:0] SymWait  = 3'd0;
    localparam logic [2:0] SymDit   = 3'd1;
    localparam logic [2:0] SymDah   = 3'd2;
    localparam logic [2:0] SymGap   = 3'd3;
    localparam logic [2:0] SymSpace = 3'd4;

    localparam logic [15:0] DitMax   = 16'(DIT_MAX);
    localparam logic [15:0] GapMin   = 16'(GAP_MIN);
    localparam logic [15:0] SpaceMin = 16'(SPACE_MIN);

    if (DIT_MAX < 1 || GAP_MIN < 1 || GAP_MIN >= SPACE_MIN || SPACE_MIN > 65535 ||
        DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("morse_symbol_classifier: illegal threshold parameters");
    end

    logic key_meta;
    logic key_s;
    logic key_db;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta <= 1'b0;
            key_s    <= 1'b0;
        end else begin
            key_meta <= key;
            key_s    <= key_meta;
        end
    end

`ifdef MORSE_DEBOUNCE_EN
    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

    logic [DbW-1:0] db_cnt;
    logic           key_db_q;

    // Counts consecutive cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt   <= '0;
            key_db_q <= 1'b0;
        end else if (key_s == key_db_q) begin
            db_cnt <= '0;
        end else if (db_cnt == DbLast) begin
            db_cnt   <= '0;
            key_db_q <= key_s;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign key_db = key_db_q;
`else
    assign key_db = key_s;
`endif

    state_e      state;
    logic [15:0] mark_cnt;
    logic [15:0] gap_cnt;
    logic [15:0] mark_inc;
    logic [15:0] gap_inc;

    assign mark_inc = (mark_cnt == 16'hFFFF) ? mark_cnt : mark_cnt + 16'd1;
    assign gap_inc  = (gap_cnt == 16'hFFFF) ? gap_cnt : gap_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            mark_cnt   <= '0;
            gap_cnt    <= '0;
            symbol     <= SymWait;
            markActive <= 1'b0;
        end else begin
            symbol <= SymWait;
            case (state)
                StIdle: begin
                    if (key_db) begin
                        state      <= StMark;
                        mark_cnt   <= 16'd1;
                        markActive <= 1'b1;
                    end
                end
                StMark: begin
                    if (key_db) begin
                        mark_cnt <= mark_inc;
                    end else begin
                        symbol     <= (mark_cnt <= DitMax) ? SymDit : SymDah;
                        state      <= StLetterGap;
                        gap_cnt    <= 16'd1;
                        markActive <= 1'b0;
                    end
                end
                StLetterGap: begin
                    // A press wins over a threshold reached in the same cycle.
                    if (key_db) begin
                        state      <= StMark;
                        mark_cnt   <= 16'd1;
                        markActive <= 1'b1;
                    end else begin
                        gap_cnt <= gap_inc;
                        if (gap_inc >= GapMin) begin
                            symbol <= SymGap;
                            state  <= StWordGap;
                        end
                    end
                end
                StWordGap: begin
                    if (key_db) begin
                        state      <= StMark;
                        mark_cnt   <= 16'd1;
                        markActive <= 1'b1;
                    end else begin
                        gap_cnt <= gap_inc;
                        if (gap_inc >= SpaceMin) begin
                            symbol <= SymSpace;
                            state  <= StIdle;
                        end
                    end
                end
                default: begin
                    state      <= StIdle;
                    markActive <= 1'b0;
                end
            endcase
        end
    end

endmodule
